// File: rtl/fetch_stage.sv
// fetch_stage: Y86 fetch PC, instruction split, next-PC prediction and F/D register
module fetch_stage #(
  parameter int          IMEM_DEPTH = 10,
  parameter logic [63:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  input  logic [79:0] inst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        bubble_d,
  input  logic        e_mispredict,
  input  logic [63:0] e_alt_pc,
  input  logic        w_ret,
  input  logic [63:0] w_valM,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_rA,
  output logic [3:0]  d_rB,
  output logic [63:0] d_valC,
  output logic [63:0] d_valP
);
  typedef enum logic [1:0] {RUN, RET_WAIT, HALTED} state_t;
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } fd_t;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam fd_t BUBBLE = {AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
  state_t state, state_n;
  fd_t fd, fd_n, f;
  logic [63:0] pc_n, pred;
  always_comb begin
    f.icode = inst[79:76];
    f.ifun  = inst[75:72];
    f.ra    = inst[71:68];
    f.rb    = inst[67:64];
    f.valc  = inst[63:0];
    f.valp  = pc + 64'd1;
    f.stat  = pc >= 64'(IMEM_DEPTH) ? ADR : f.icode > 4'hB ? INS : f.icode == 4'h0 ? HLT : AOK;
    pred    = (f.icode == 4'h7 || f.icode == 4'h8) ? f.valc : f.valp;
  end
  // Mispredict beats everything, including stalls: whatever is in flight is on the wrong path.
  always_comb begin
    pc_n    = pc;
    state_n = state;
    fd_n    = fd;
    if (e_mispredict) begin
      pc_n    = e_alt_pc;
      state_n = RUN;
      fd_n    = BUBBLE;
    end else if (state == RET_WAIT && w_ret) begin
      pc_n    = w_valM;
      state_n = RUN;
      fd_n    = BUBBLE;
    end else if (state != RUN) begin
      fd_n = stall_d ? fd : BUBBLE;
    end else begin
      pc_n = stall_f ? pc : pred;
      fd_n = stall_d ? fd : bubble_d ? BUBBLE : f;
      if (!stall_d && !bubble_d)
        state_n = f.stat != AOK ? HALTED : f.icode == 4'h9 ? RET_WAIT : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
      fd    <= BUBBLE;
    end else begin
      pc    <= pc_n;
      state <= state_n;
      fd    <= fd_n;
    end
  end
  assign d_stat  = fd.stat;
  assign d_icode = fd.icode;
  assign d_ifun  = fd.ifun;
  assign d_rA    = fd.ra;
  assign d_rB    = fd.rb;
  assign d_valC  = fd.valc;
  assign d_valP  = fd.valp;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed vectors plus reset-recovery sequences for fetch_stage
module tb_fetch_stage;
  logic        clk = 0;
  logic        reset, stall_f, stall_d, bubble_d, e_mispredict, w_ret;
  logic [63:0] e_alt_pc, w_valM, pc, d_valC, d_valP;
  logic [79:0] inst;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
  logic [79:0] mem [16];
  int total = 0, bad = 0;

  typedef struct {
    logic sf, sd, bd, mis;
    logic [63:0] alt;
    logic wr;
    logic [63:0] wv, pc;
    logic [2:0] st;
    logic [3:0] ic, fn, ra, rb;
    logic [63:0] vc, vp;
  } vec_t;
  vec_t vecs[$];

  fetch_stage #(.IMEM_DEPTH(10), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_d(bubble_d),
    .e_mispredict(e_mispredict), .e_alt_pc(e_alt_pc),
    .w_ret(w_ret), .w_valM(w_valM),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP)
  );

  always #5 clk = ~clk;
  // Out-of-range fetches return an INS-looking word so ADR priority is exercised.
  assign inst = (pc < 64'd10) ? mem[pc[3:0]] : 80'hC1230000000000000000;

  function automatic vec_t v(input logic sf, sd, bd, mis, input logic [63:0] alt,
                             input logic wr, input logic [63:0] wv, epc,
                             input logic [2:0] st, input logic [3:0] ic, fn, ra, rb,
                             input logic [63:0] vc, vp);
    vec_t x;
    x.sf = sf; x.sd = sd; x.bd = bd; x.mis = mis; x.alt = alt; x.wr = wr; x.wv = wv;
    x.pc = epc; x.st = st; x.ic = ic; x.fn = fn; x.ra = ra; x.rb = rb; x.vc = vc; x.vp = vp;
    return x;
  endfunction

  function automatic vec_t b(input logic sf, sd, bd, mis, input logic [63:0] alt,
                             input logic wr, input logic [63:0] wv, epc);
    return v(sf, sd, bd, mis, alt, wr, wv, epc, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
  endfunction

  task automatic check(input string nm, input vec_t x);
    total++;
    if ({pc, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP} !==
        {x.pc, x.st, x.ic, x.fn, x.ra, x.rb, x.vc, x.vp}) begin
      bad++;
      $display("FAIL %s: got pc=%h stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h exp pc=%h stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h",
               nm, pc, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
               x.pc, x.st, x.ic, x.fn, x.ra, x.rb, x.vc, x.vp);
    end
  endtask

  task automatic apply(input string nm, input vec_t x);
    stall_f = x.sf; stall_d = x.sd; bubble_d = x.bd; e_mispredict = x.mis;
    e_alt_pc = x.alt; w_ret = x.wr; w_valM = x.wv;
    @(posedge clk); #1;
    check(nm, x);
  endtask

  task automatic do_reset(input string nm);
    reset = 1;
    stall_f = 0; stall_d = 0; bubble_d = 0; e_mispredict = 0; w_ret = 0;
    @(posedge clk); #1;
    check(nm, b(0, 0, 0, 0, 0, 0, 0, 64'd0));
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 80'h30F3000000000000000C;
    mem[1] = 80'h30F20000000000000008;
    mem[2] = 80'h60230000000000000000;
    mem[3] = 80'h20320000000000000000;
    mem[4] = 80'h90FF0000000000000000;
    mem[5] = 80'hA02F0000000000000000;
    mem[6] = 80'h80FF0000000000000004;
    mem[7] = 80'hC0000000000000000000;
    mem[8] = 80'h74000000000000000002;
    mem[9] = 80'h00000000000000000000;
    reset = 1; stall_f = 0; stall_d = 0; bubble_d = 0;
    e_mispredict = 0; e_alt_pc = 0; w_ret = 0; w_valM = 0;
    @(posedge clk);
    do_reset("reset");

    vecs.push_back(v(0,0,0,0,0,0,0, 1, 1,4'h3,0,4'hF,4'h3,64'h0C,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 2, 1,4'h3,0,4'hF,4'h2,64'h08,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 3, 1,4'h6,0,4'h2,4'h3,0,3));
    vecs.push_back(v(1,1,0,0,0,0,0, 3, 1,4'h6,0,4'h2,4'h3,0,3));
    vecs.push_back(v(1,1,0,0,0,0,0, 3, 1,4'h6,0,4'h2,4'h3,0,3));
    vecs.push_back(v(1,1,0,0,0,0,0, 3, 1,4'h6,0,4'h2,4'h3,0,3));
    vecs.push_back(v(0,0,0,0,0,0,0, 4, 1,4'h2,0,4'h3,4'h2,0,4));
    vecs.push_back(b(0,0,1,0,0,0,0, 5));
    vecs.push_back(b(0,0,0,1,8,0,0, 8));
    vecs.push_back(v(0,0,0,0,0,0,0, 2, 1,4'h7,4'h4,0,0,2,9));
    vecs.push_back(b(1,1,0,1,9,0,0, 9));
    vecs.push_back(v(1,0,0,0,0,0,0, 9, 2,4'h0,0,0,0,0,10));
    vecs.push_back(b(0,0,0,0,0,0,0, 9));
    vecs.push_back(b(0,0,0,0,0,1,5, 9));
    vecs.push_back(b(0,1,0,0,0,0,0, 9));
    vecs.push_back(b(1,0,1,0,0,0,0, 9));
    vecs.push_back(b(0,0,0,0,0,0,0, 9));
    vecs.push_back(b(0,0,0,1,3,0,0, 3));
    vecs.push_back(v(0,0,0,0,0,0,0, 4, 1,4'h2,0,4'h3,4'h2,0,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 5, 1,4'h9,0,4'hF,4'hF,0,5));
    vecs.push_back(b(0,0,0,0,0,0,0, 5));
    vecs.push_back(b(1,0,0,0,0,0,0, 5));
    vecs.push_back(b(0,1,0,0,0,0,0, 5));
    vecs.push_back(b(0,0,0,0,0,0,0, 5));
    vecs.push_back(b(0,0,0,0,0,1,5, 5));
    vecs.push_back(v(0,0,0,0,0,0,0, 6, 1,4'hA,0,4'h2,4'hF,0,6));
    vecs.push_back(v(0,0,0,0,0,0,0, 4, 1,4'h8,0,4'hF,4'hF,4,7));
    vecs.push_back(v(0,0,0,0,0,0,0, 5, 1,4'h9,0,4'hF,4'hF,0,5));
    vecs.push_back(b(0,0,0,0,0,1,2, 2));
    vecs.push_back(v(0,0,0,0,0,0,0, 3, 1,4'h6,0,4'h2,4'h3,0,3));
    vecs.push_back(v(0,0,0,0,0,0,0, 4, 1,4'h2,0,4'h3,4'h2,0,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 5, 1,4'h9,0,4'hF,4'hF,0,5));
    vecs.push_back(b(0,0,0,1,7,0,0, 7));
    vecs.push_back(v(0,0,0,0,0,0,0, 8, 4,4'hC,0,0,0,0,8));
    vecs.push_back(b(0,0,0,0,0,0,0, 8));
    vecs.push_back(b(0,0,0,1,12,0,0, 12));
    vecs.push_back(v(0,0,0,0,0,0,0, 13, 3,4'hC,4'h1,4'h2,4'h3,0,13));
    vecs.push_back(b(0,0,0,0,0,0,0, 13));
    vecs.push_back(b(0,0,0,1,'1,0,0, '1));
    vecs.push_back(v(0,0,0,0,0,0,0, 0, 3,4'hC,4'h1,4'h2,4'h3,0,0));
    vecs.push_back(b(0,0,0,0,0,0,0, 0));
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    do_reset("rst_in_halted");
    apply("run_after_halt_rst", v(0,0,0,0,0,0,0, 1, 1,4'h3,0,4'hF,4'h3,64'h0C,1));

    apply("redir_to_ret", b(0,0,0,1,4,0,0, 4));
    apply("ret_fetch", v(0,0,0,0,0,0,0, 5, 1,4'h9,0,4'hF,4'hF,0,5));
    apply("ret_wait", b(0,0,0,0,0,0,0, 5));
    do_reset("rst_in_ret_wait");
    apply("run_after_ret_rst", v(0,0,0,0,0,0,0, 1, 1,4'h3,0,4'hF,4'h3,64'h0C,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Pipeline fetch stage of the Y86 processor. Holds the fetch PC, drives it to the instruction memory, and splits the returned 80-bit instruction word into icode/ifun/rA/rB/valC. It predicts the next PC and loads the F/D pipeline register consumed by decode. It recovers from branch mispredictions and waits for `ret` targets internally. PC is an instruction index, one per 80-bit word, so valP = pc + 1 and jump/call targets in valC are instruction indices.

## Interface
- `IMEM_DEPTH`, 10: number of valid instruction indices; any pc >= IMEM_DEPTH is an address error.
- `RESET_PC`, 0: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` out 64: current fetch PC, driven to instruction memory.
- `inst` in 80: instruction word for `pc`, combinational, same cycle.
- `stall_f` in 1: hold fetch PC.
- `stall_d` in 1: hold F/D register.
- `bubble_d` in 1: load nop bubble into F/D register.
- `e_mispredict` in 1: branch in execute was mispredicted.
- `e_alt_pc` in 64: correct PC for the mispredicted branch.
- `w_ret` in 1: a `ret` is retiring this cycle.
- `w_valM` in 64: return address of the retiring `ret`.
- `d_stat` out 3; `d_icode` out 4; `d_ifun` out 4; `d_rA` out 4; `d_rB` out 4; `d_valC` out 64; `d_valP` out 64: F/D register contents.

## Operation
- Field split: icode = inst[79:76], ifun = inst[75:72], rA = inst[71:68], rB = inst[67:64], valC = inst[63:0] for every format. Unused fields pass through unchanged.
- Status encodings: AOK=1, HLT=2, ADR=3, INS=4.
- Status priority: pc >= IMEM_DEPTH gives ADR. Otherwise icode > 4'hB gives INS. Otherwise icode 0 gives HLT. Everything else is AOK.
- Bubble value: stat AOK, icode 1 (nop), ifun 0, rA = rB = 4'hF, valC 0, valP 0.
- Predicted PC: icode 7 (jXX, all ifun) or icode 8 (call) selects valC. All other icodes select pc + 1. Arithmetic is 64-bit, wraps modulo 2^64.
- States:
  - RUN: fetches normally.
  - RET_WAIT: entered when a `ret` (icode 9, AOK) is fetched.
  - HALTED: entered when a non-AOK status is fetched.
- Per-cycle update, first matching rule wins:
  1. reset: pc <= RESET_PC, state RUN, F/D <= bubble.
  2. e_mispredict: pc <= e_alt_pc, state RUN, F/D <= bubble. This applies in any state and overrides stalls, because the fetched path is wrong.
  3. RET_WAIT with w_ret: pc <= w_valM, state RUN, F/D <= bubble.
  4. RET_WAIT or HALTED (no event): pc holds. F/D holds if stall_d, else bubble.
  5. RUN:
     - pc <= predicted PC unless stall_f.
     - F/D: stall_d holds it. Otherwise bubble_d loads bubble. Otherwise it loads the fetched fields plus d_stat and d_valP = pc + 1.
     - The state change to RET_WAIT or HALTED happens only when the instruction is actually loaded into F/D. An instruction that is stalled or bubbled does not change state.
- w_ret while in RUN or HALTED is ignored.

## Timing
- pc is the registered value, and the fetched instruction is sampled at the same edge: a 1-cycle F-to-D latency.
- After reset deasserts, the first instruction appears on the d_* outputs one edge later.
- Mispredict redirect: e_alt_pc is on `pc` in the cycle after e_mispredict is asserted. That instruction reaches F/D one cycle later.
- Ret: F/D carries bubbles from the cycle after `ret` is loaded until the cycle after w_ret. The target is on `pc` the cycle after w_ret.
- Reset asserted mid-RET_WAIT or mid-HALTED returns the block to RUN at RESET_PC with a bubble in F/D.

## Test plan
- Reset, then run with no stalls from pc=0 through the HCF program:
  - Edge 1: d_icode 3, d_rB 3, d_valC 0x0c, d_valP 1.
  - Edge 2: d_valC 0x08.
  - pc sequence is 0, 1, 2, ...
- jne at pc=8 (inst 0x74000000000000000002):
  - Required: d_valC 2, d_valP 9, next pc 2.
  - Then pulse e_mispredict with e_alt_pc=9: pc=9 next cycle, F/D is a bubble, no state change.
- pc=9 fetches HLT: d_stat 2, state HALTED.
  - Then pc stays 9 and F/D is all bubbles for 5 cycles.
  - Then e_mispredict with e_alt_pc=3: fetch resumes in RUN at pc=3.
- pc=12 with IMEM_DEPTH=10: d_stat 3 (ADR), HALTED.
- Fetch inst 0x90… (ret):
  - F/D carries bubbles for 4 cycles.
  - w_ret with w_valM=5: pc=5 next cycle, then icode at index 5 enters F/D.
- stall_f and stall_d held 3 cycles mid-stream: pc and all d_* unchanged.
- bubble_d alone: d_icode 1 and pc advances.
- e_mispredict while stall_f=1: redirect still occurs.
